ex_operand_stage: RTL and testbench

- ID/EX pipeline stage sitting directly upstream of the ALU.
- Registers one decoded instruction and resolves rs1/rs2 through MEM/WB forwarding (or interlock).
- Selects ALU operands and presents srcA/srcB/alu_opcode to the ALU with a valid/ready handshake.
- Handles load-use stalls and pipeline flush.

---
 rtl/ex_stage_pkg.sv | 35 +++
 rtl/ex_operand_stage_fwd_unit.sv | 48 ++++
 rtl/ex_operand_stage.sv | 122 ++++++++++++
 tb/tb_ex_operand_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared types and constants for the ID/EX operand stage
package ex_stage_pkg;

    localparam int XLEN_P    = 32;
    localparam int RADDR_W_P = 5;
    localparam int OPC_W_P   = 4;

    typedef enum logic [1:0] {
        A_RS1      = 2'd0,
        A_PC       = 2'd1,
        A_ZERO     = 2'd2,
        A_ZERO_ALT = 2'd3
    } a_sel_e;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2,
        B_ZERO = 2'd3
    } b_sel_e;

    localparam logic [XLEN_P-1:0] CONST_FOUR = XLEN_P'(4);

    typedef struct packed {
        logic [XLEN_P-1:0]    src_a;
        logic [XLEN_P-1:0]    src_b;
        logic [OPC_W_P-1:0]   alu_opcode;
        logic [XLEN_P-1:0]    store_data;
        logic [XLEN_P-1:0]    pc;
        logic [XLEN_P-1:0]    imm;
        logic [RADDR_W_P-1:0] rd_addr;
        logic                 rd_we;
    } ex_bundle_t;

endpackage

// File: rtl/ex_operand_stage_fwd_unit.sv
// rtl/ex_operand_stage_fwd_unit.sv - per-source operand resolution (FWD_EN selects bypass vs full interlock)
module fwd_unit #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] addr,
    input  logic [XLEN-1:0]    rf_data,
    input  logic [RADDR_W-1:0] mem_rd_addr,
    input  logic               mem_rd_we,
    input  logic               mem_is_load,
    input  logic [XLEN-1:0]    mem_result,
    input  logic [RADDR_W-1:0] wb_rd_addr,
    input  logic               wb_rd_we,
    input  logic [XLEN-1:0]    wb_result,
    output logic [XLEN-1:0]    value,
    output logic               load_hit
);

    logic addr_nz;
    logic mem_match;
    logic wb_match;

    assign addr_nz   = (addr != '0);
    assign mem_match = mem_rd_we && (mem_rd_addr == addr);
    assign wb_match  = wb_rd_we && (wb_rd_addr == addr);

`ifdef FWD_EN
    // Only a pending load cannot be bypassed; every other producer forwards.
    assign load_hit = addr_nz && mem_match && mem_is_load;

    always_comb begin
        value = rf_data;
        if (!addr_nz)
            value = '0;
        else if (mem_match && !mem_is_load)
            value = mem_result;
        else if (wb_match)
            value = wb_result;
    end
`else
    // Without bypass paths any in-flight writer of this register must drain first.
    logic unused_fwd;
    assign unused_fwd = ^{mem_is_load, mem_result, wb_result};
    assign load_hit   = addr_nz && (mem_match || wb_match);
    assign value      = addr_nz ? rf_data : '0;
`endif

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with operand forwarding/interlock feeding the ALU
// Build option: FWD_EN enables MEM/WB bypass; otherwise a full interlock is used.
module ex_operand_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN    = XLEN_P,
    parameter int RADDR_W = RADDR_W_P,
    parameter int OPC_W   = OPC_W_P
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [RADDR_W-1:0] id_rs1_addr,
    input  logic [RADDR_W-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [1:0]         id_a_sel,
    input  logic [1:0]         id_b_sel,
    input  logic [OPC_W-1:0]   id_alu_opcode,
    input  logic [RADDR_W-1:0] id_rd_addr,
    input  logic               id_rd_we,
    input  logic [RADDR_W-1:0] mem_rd_addr,
    input  logic               mem_rd_we,
    input  logic               mem_is_load,
    input  logic [XLEN-1:0]    mem_result,
    input  logic [RADDR_W-1:0] wb_rd_addr,
    input  logic               wb_rd_we,
    input  logic [XLEN-1:0]    wb_result,
    input  logic               flush,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [XLEN-1:0]    src_a,
    output logic [XLEN-1:0]    src_b,
    output logic [OPC_W-1:0]   alu_opcode,
    output logic [XLEN-1:0]    ex_store_data,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_imm,
    output logic [RADDR_W-1:0] ex_rd_addr,
    output logic               ex_rd_we
);

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            rs1_hit;
    logic            rs2_hit;
    logic            hazard;
    logic            accept;
    logic            valid_q, valid_d;
    ex_bundle_t      ex_q, ex_d;

    fwd_unit #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
        .addr(id_rs1_addr), .rf_data(id_rs1_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_we(mem_rd_we), .mem_is_load(mem_is_load),
        .mem_result(mem_result), .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we),
        .wb_result(wb_result), .value(rs1_val), .load_hit(rs1_hit)
    );

    fwd_unit #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
        .addr(id_rs2_addr), .rf_data(id_rs2_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_we(mem_rd_we), .mem_is_load(mem_is_load),
        .mem_result(mem_result), .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we),
        .wb_result(wb_result), .value(rs2_val), .load_hit(rs2_hit)
    );

    // Stores carry rs2 with b_sel != 0, so any rs2 match is treated as a use.
    assign hazard   = (a_sel_e'(id_a_sel) == A_RS1 && rs1_hit) || rs2_hit;
    assign id_ready = !flush && !hazard && (!valid_q || ex_ready);
    assign accept   = id_valid && id_ready;

    always_comb begin
        ex_d    = ex_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            case (a_sel_e'(id_a_sel))
                A_RS1:   ex_d.src_a = rs1_val;
                A_PC:    ex_d.src_a = id_pc;
                default: ex_d.src_a = '0;
            endcase
            case (b_sel_e'(id_b_sel))
                B_RS2:   ex_d.src_b = rs2_val;
                B_IMM:   ex_d.src_b = id_imm;
                B_FOUR:  ex_d.src_b = CONST_FOUR;
                default: ex_d.src_b = '0;
            endcase
            ex_d.alu_opcode = id_alu_opcode;
            ex_d.store_data = rs2_val;
            ex_d.pc         = id_pc;
            ex_d.imm        = id_imm;
            ex_d.rd_addr    = id_rd_addr;
            ex_d.rd_we      = id_rd_we;
        end else if (ex_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ex_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ex_q    <= ex_d;
        end
    end

    assign ex_valid      = valid_q;
    assign src_a         = ex_q.src_a;
    assign src_b         = ex_q.src_b;
    assign alu_opcode    = ex_q.alu_opcode;
    assign ex_store_data = ex_q.store_data;
    assign ex_pc         = ex_q.pc;
    assign ex_imm        = ex_q.imm;
    assign ex_rd_addr    = ex_q.rd_addr;
    assign ex_rd_we      = ex_q.rd_we;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed self-checking bench for ex_operand_stage
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs1_addr, id_rs2_addr;
    logic [31:0] id_rs1_data, id_rs2_data;
    logic [31:0] id_pc, id_imm;
    logic [1:0]  id_a_sel, id_b_sel;
    logic [3:0]  id_alu_opcode;
    logic [4:0]  id_rd_addr;
    logic        id_rd_we;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_we, mem_is_load;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_we;
    logic [31:0] wb_result;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] src_a, src_b;
    logic [3:0]  alu_opcode;
    logic [31:0] ex_store_data, ex_pc, ex_imm;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_we;

    int n_vec = 0;
    int n_err = 0;

    ex_operand_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_pc(id_pc), .id_imm(id_imm),
        .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
        .id_alu_opcode(id_alu_opcode), .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
        .mem_rd_addr(mem_rd_addr), .mem_rd_we(mem_rd_we), .mem_is_load(mem_is_load),
        .mem_result(mem_result),
        .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we), .wb_result(wb_result),
        .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .src_a(src_a), .src_b(src_b), .alu_opcode(alu_opcode),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (got running, need finished)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2,
                         input logic [1:0] asel, input logic [1:0] bsel,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [3:0] opc, input logic [4:0] rd);
        id_rs1_addr = rs1; id_rs1_data = d1;
        id_rs2_addr = rs2; id_rs2_data = d2;
        id_a_sel = asel;   id_b_sel = bsel;
        id_pc = pc;        id_imm = imm;
        id_alu_opcode = opc;
        id_rd_addr = rd;   id_rd_we = 1'b1;
    endtask

    task automatic clear_prod();
        mem_rd_addr = '0; mem_rd_we = 1'b0; mem_is_load = 1'b0; mem_result = '0;
        wb_rd_addr = '0;  wb_rd_we = 1'b0;  wb_result = '0;
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        instr(5'd0, 32'd0, 5'd0, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0, 4'd0, 5'd0);
        id_rd_we = 1'b0;
        clear_prod();

        // Reset
        step(); step();
        check("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("reset_src_a", src_a, 32'd0);
        check("reset_src_b", src_b, 32'd0);
        rst = 1'b0;
        settle();
        check("reset_id_ready", {31'd0, id_ready}, 32'd1);

        // Plain register operands
        instr(5'd5, 32'd7, 5'd6, 32'd9, 2'd0, 2'd0, 32'h100, 32'd0, 4'h1, 5'd7);
        id_valid = 1'b1;
        step();
        check("add_ex_valid", {31'd0, ex_valid}, 32'd1);
        check("add_src_a", src_a, 32'd7);
        check("add_src_b", src_b, 32'd9);
        check("add_opcode", {28'd0, alu_opcode}, 32'h1);
        check("add_rd", {27'd0, ex_rd_addr}, 32'd7);
        check("add_store", ex_store_data, 32'd9);
        check("add_pc", ex_pc, 32'h100);

        // Operand selects
        instr(5'd5, 32'd7, 5'd6, 32'd9, 2'd1, 2'd2, 32'h1000, 32'd0, 4'h2, 5'd1);
        step();
        check("sel_pc_a", src_a, 32'h1000);
        check("sel_four_b", src_b, 32'd4);
        instr(5'd5, 32'd7, 5'd6, 32'd9, 2'd2, 2'd1, 32'h1000, 32'hFFFF_FFF0, 4'h3, 5'd1);
        step();
        check("sel_zero_a", src_a, 32'd0);
        check("sel_imm_b", src_b, 32'hFFFF_FFF0);
        check("sel_imm_out", ex_imm, 32'hFFFF_FFF0);
        instr(5'd5, 32'd7, 5'd6, 32'd9, 2'd3, 2'd3, 32'h1000, 32'd0, 4'h3, 5'd1);
        step();
        check("sel3_a", src_a, 32'd0);
        check("sel3_b", src_b, 32'd0);

        // Backpressure
        instr(5'd1, 32'h11, 5'd2, 32'h22, 2'd0, 2'd0, 32'h180, 32'd0, 4'h4, 5'd3);
        step();
        check("bp_first_a", src_a, 32'h11);
        ex_ready = 1'b0;
        instr(5'd1, 32'h33, 5'd2, 32'h44, 2'd0, 2'd0, 32'h200, 32'd0, 4'h5, 5'd4);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_id_ready", {31'd0, id_ready}, 32'd0);
            step();
            check("bp_hold_valid", {31'd0, ex_valid}, 32'd1);
            check("bp_hold_a", src_a, 32'h11);
            check("bp_hold_pc", ex_pc, 32'h180);
        end
        ex_ready = 1'b1;
        settle();
        check("bp_release_ready", {31'd0, id_ready}, 32'd1);
        step();
        check("bp_new_a", src_a, 32'h33);
        check("bp_new_pc", ex_pc, 32'h200);

        // Drain
        id_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, ex_valid}, 32'd0);

        // Flush over held instruction with incoming valid
        instr(5'd1, 32'h44, 5'd2, 32'h0, 2'd0, 2'd0, 32'h300, 32'd0, 4'h6, 5'd5);
        id_valid = 1'b1;
        step();
        check("flush_pre_a", src_a, 32'h44);
        ex_ready = 1'b0;
        flush = 1'b1;
        instr(5'd1, 32'h55, 5'd2, 32'h0, 2'd0, 2'd0, 32'h304, 32'd0, 4'h6, 5'd5);
        settle();
        check("flush_id_ready", {31'd0, id_ready}, 32'd0);
        step();
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        step();
        check("flush_no_ghost", {31'd0, ex_valid}, 32'd0);

        // Load-use on rs1
        instr(5'd3, 32'h66, 5'd0, 32'd0, 2'd0, 2'd1, 32'h400, 32'd0, 4'h1, 5'd8);
        id_valid = 1'b1;
        mem_rd_we = 1'b1; mem_is_load = 1'b1; mem_rd_addr = 5'd3; mem_result = 32'h77;
        settle();
        check("lu_stall", {31'd0, id_ready}, 32'd0);
        step();
        check("lu_no_issue", {31'd0, ex_valid}, 32'd0);
        id_a_sel = 2'd1;
        settle();
        check("lu_rs1_unused", {31'd0, id_ready}, 32'd1);
        id_a_sel = 2'd0;
        settle();
        check("lu_rs1_used", {31'd0, id_ready}, 32'd0);
        mem_is_load = 1'b0;
`ifdef FWD_EN
        settle();
        check("lu_release", {31'd0, id_ready}, 32'd1);
        step();
        check("lu_fwd_a", src_a, 32'h77);
`else
        settle();
        check("il_mem_stall", {31'd0, id_ready}, 32'd0);
        step();
        check("il_mem_no_issue", {31'd0, ex_valid}, 32'd0);
        mem_rd_we = 1'b0;
        settle();
        check("il_release", {31'd0, id_ready}, 32'd1);
        step();
        check("il_rf_a", src_a, 32'h66);
`endif
        id_valid = 1'b0;
        clear_prod();
        step();

        // Load on rs2 always stalls; x0 never does
        instr(5'd0, 32'd0, 5'd6, 32'd9, 2'd0, 2'd1, 32'h500, 32'h8, 4'h0, 5'd0);
        id_valid = 1'b1;
        mem_rd_we = 1'b1; mem_is_load = 1'b1; mem_rd_addr = 5'd6;
        settle();
        check("store_rs2_stall", {31'd0, id_ready}, 32'd0);
        mem_rd_addr = 5'd0;
        settle();
        check("x0_load_no_stall", {31'd0, id_ready}, 32'd1);
        id_valid = 1'b0;
        clear_prod();
        step();

`ifdef FWD_EN
        // Forwarding priority
        instr(5'd5, 32'd7, 5'd6, 32'd9, 2'd0, 2'd0, 32'h600, 32'd0, 4'h1, 5'd9);
        id_valid = 1'b1;
        mem_rd_we = 1'b1; mem_rd_addr = 5'd5; mem_result = 32'd100;
        wb_rd_we = 1'b1;  wb_rd_addr = 5'd6;  wb_result = 32'd200;
        step();
        check("fwd_mem_a", src_a, 32'd100);
        check("fwd_wb_b", src_b, 32'd200);
        check("fwd_wb_store", ex_store_data, 32'd200);
        wb_rd_addr = 5'd5; wb_result = 32'd300;
        step();
        check("fwd_mem_wins", src_a, 32'd100);
        check("fwd_rf_b", src_b, 32'd9);
        mem_rd_we = 1'b0;
        step();
        check("fwd_wb_a", src_a, 32'd300);
        instr(5'd0, 32'hDEAD, 5'd6, 32'd9, 2'd0, 2'd0, 32'h700, 32'd0, 4'h1, 5'd9);
        mem_rd_we = 1'b1; mem_rd_addr = 5'd0; mem_result = 32'd123;
        step();
        check("fwd_x0_a", src_a, 32'd0);
`else
        // Full interlock on WB and MEM writers
        instr(5'd5, 32'd7, 5'd6, 32'd9, 2'd0, 2'd0, 32'h600, 32'd0, 4'h1, 5'd9);
        id_valid = 1'b1;
        wb_rd_we = 1'b1; wb_rd_addr = 5'd6; wb_result = 32'd200;
        settle();
        check("il_wb_stall", {31'd0, id_ready}, 32'd0);
        step();
        check("il_wb_no_issue", {31'd0, ex_valid}, 32'd0);
        settle();
        check("il_wb_still", {31'd0, id_ready}, 32'd0);
        wb_rd_we = 1'b0;
        settle();
        check("il_wb_release", {31'd0, id_ready}, 32'd1);
        step();
        check("il_wb_rf_b", src_b, 32'd9);
        check("il_wb_rf_a", src_a, 32'd7);
        instr(5'd0, 32'hDEAD, 5'd6, 32'd9, 2'd0, 2'd0, 32'h700, 32'd0, 4'h1, 5'd9);
        mem_rd_we = 1'b1; mem_rd_addr = 5'd0; mem_result = 32'd123;
        settle();
        check("il_x0_ready", {31'd0, id_ready}, 32'd1);
        step();
        check("il_x0_a", src_a, 32'd0);
`endif

        // Reset mid-operation
        check("midrst_pre_valid", {31'd0, ex_valid}, 32'd1);
        rst = 1'b1;
        step();
        check("midrst_valid", {31'd0, ex_valid}, 32'd0);
        check("midrst_b", src_b, 32'd0);
        check("midrst_pc", ex_pc, 32'd0);
        check("midrst_rd_we", {31'd0, ex_rd_we}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
